// File: rtl/trace_log_arbiter.sv
// Round-robin arbiter that shares one debug log channel between N_REQ requesters and timestamps each record.
// Latency: 1 cycle from accept to log_valid; sustains 1 record/cycle while log_ready stays high.
// Backpressure: log_valid && !log_ready holds the record and deasserts req_ready; with log_en=0 requests are accepted and dropped.
// Optional: define TRACE_LOG_PRINTF_EN to print every delivered record (simulation only).
module trace_log_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int TS_W   = 32,
    parameter int ID_W   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    log_en,
    output logic                    log_valid,
    input  logic                    log_ready,
    output logic [TS_W-1:0]         log_ts,
    output logic [ID_W-1:0]         log_id,
    output logic [DATA_W-1:0]       log_data,
    output logic [TS_W-1:0]         tsc,
    output logic [15:0]             drop_cnt
);

    logic [ID_W-1:0]    rr_ptr;
    logic [2*N_REQ-1:0] dbl_valid;
    logic [N_REQ-1:0]   rot_valid;
    logic [ID_W-1:0]    offset;
    logic [ID_W:0]      grant_sum;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    next_ptr;
    logic               any_req;
    logic               slot_free;
    logic               accept;
    logic [DATA_W-1:0]  grant_data;

    // Rotate requests so rr_ptr lands at bit 0, pick the lowest set bit, then rotate the index back.
    always_comb begin
        dbl_valid = {req_valid, req_valid} >> rr_ptr;
        rot_valid = dbl_valid[N_REQ-1:0];
        offset    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                offset = ID_W'(k);
            end
        end
        any_req   = |req_valid;
        grant_sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (grant_sum >= (ID_W+1)'(N_REQ)) begin
            grant_sum = grant_sum - (ID_W+1)'(N_REQ);
        end
        grant    = grant_sum[ID_W-1:0];
        next_ptr = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    end

    // Payload mux for the winning requester.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(grant) == i) begin
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grant only into a free slot when forwarding; when discarding, the slot is irrelevant.
    always_comb begin
        slot_free = !log_valid || log_ready;
        req_ready = '0;
        if (!reset && any_req && (!log_en || slot_free)) begin
            req_ready[grant] = 1'b1;
        end
        accept = |(req_valid & req_ready);
    end

    // Timestamp counter, round-robin pointer, output record register and drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            tsc       <= '0;
            drop_cnt  <= '0;
            rr_ptr    <= '0;
            log_valid <= 1'b0;
            log_ts    <= '0;
            log_id    <= '0;
            log_data  <= '0;
        end else begin
            tsc <= tsc + 1'b1;
            if (accept) begin
                rr_ptr <= next_ptr;
            end
            if (accept && log_en) begin
                log_valid <= 1'b1;
                log_ts    <= tsc;
                log_id    <= grant;
                log_data  <= grant_data;
            end else if (slot_free) begin
                log_valid <= 1'b0;
            end
            if (accept && !log_en && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

`ifdef TRACE_LOG_PRINTF_EN
`ifndef SYNTHESIS
    // Print each record as the sink takes it.
    always @(posedge clk) begin
        if (!reset && log_valid && log_ready) begin
            $display("Cyc= %d src %d: %h", log_ts, log_id, log_data);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_trace_log_arbiter.sv
// Bench for trace_log_arbiter: directed checks of the main scenarios plus randomized traffic against a queue-free model.
// A default instance and a TS_W=8 instance share stimulus; the model checks both every cycle.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_trace_log_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic        log_en;
    logic        log_ready;

    logic [3:0]  req_ready,  req_ready8;
    logic        log_valid,  log_valid8;
    logic [31:0] log_ts,     tsc;
    logic [7:0]  log_ts8,    tsc8;
    logic [1:0]  log_id,     log_id8;
    logic [15:0] log_data,   log_data8;
    logic [15:0] drop_cnt,   drop_cnt8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trace_log_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .log_en(log_en), .log_valid(log_valid),
        .log_ready(log_ready), .log_ts(log_ts), .log_id(log_id),
        .log_data(log_data), .tsc(tsc), .drop_cnt(drop_cnt)
    );

    trace_log_arbiter #(.TS_W(8)) dut8 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready8), .log_en(log_en), .log_valid(log_valid8),
        .log_ready(log_ready), .log_ts(log_ts8), .log_id(log_id8),
        .log_data(log_data8), .tsc(tsc8), .drop_cnt(drop_cnt8)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state: what the registered outputs must be in the current cycle.
    logic [31:0] m_tsc   = 0;
    logic [31:0] m_ts    = 0;
    int          m_ptr   = 0;
    bit          m_valid = 0;
    int          m_id    = 0;
    logic [15:0] m_data  = 0;
    int          m_drop  = 0;

    int          g;
    bit          free_slot;
    logic [3:0]  exp_rdy;

    // Compare process: check both DUTs against the model, then advance the model across the next edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            g = -1;
            exp_rdy = 4'b0;
            if (!reset) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                end
            end
            free_slot = !m_valid || log_ready;
            if (g >= 0 && (!log_en || free_slot)) exp_rdy[g] = 1'b1;

            chk("req_ready", req_ready, exp_rdy);
            chk("log_valid", log_valid, m_valid);
            chk("log_ts", log_ts, m_ts);
            chk("log_id", log_id, m_id);
            chk("log_data", log_data, m_data);
            chk("tsc", tsc, m_tsc);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("req_ready8", req_ready8, exp_rdy);
            chk("log_valid8", log_valid8, m_valid);
            chk("log_ts8", log_ts8, m_ts[7:0]);
            chk("log_id8", log_id8, m_id);
            chk("log_data8", log_data8, m_data);
            chk("tsc8", tsc8, m_tsc[7:0]);
            chk("drop_cnt8", drop_cnt8, m_drop);

            if (reset) begin
                m_tsc = 0; m_ts = 0; m_ptr = 0; m_valid = 0;
                m_id = 0; m_data = 0; m_drop = 0;
            end else begin
                if (exp_rdy != 4'b0 && log_en) begin
                    m_valid = 1;
                    m_ts    = m_tsc;
                    m_id    = g;
                    m_data  = req_data[g*16 +: 16];
                end else if (free_slot) begin
                    m_valid = 0;
                end
                if (exp_rdy != 4'b0) m_ptr = (g + 1) % 4;
                if (exp_rdy != 4'b0 && !log_en && m_drop < 65535) m_drop++;
                m_tsc = m_tsc + 1;
            end
        end
    end

    logic [31:0] prev_ts;
    int          n;

    // Stimulus with literal expectations that pin the model.
    initial begin
        reset = 1'b1; req_valid = 4'b1111; req_data = '0; log_en = 1'b1; log_ready = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_log_valid", log_valid, 0);
        chk("rst_tsc", tsc, 0);
        chk("rst_drop", drop_cnt, 0);
        cyc();
        reset = 1'b0; req_valid = 4'b0;

        // Counter starts from 0 after release.
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("tsc_count", tsc, t);
            cyc();
        end

        // Single request at tsc=5.
        n = 0;
        while (tsc != 5 && n < 20) begin cyc(); n++; end
        chk("reach_tsc5", tsc, 5);
        req_valid = 4'b0001; req_data[15:0] = 16'hABCD;
        @(negedge clk);
        chk("single_rdy", req_ready, 4'b0001);
        cyc();
        req_valid = 4'b0;
        @(negedge clk);
        chk("single_valid", log_valid, 1);
        chk("single_ts", log_ts, 5);
        chk("single_id", log_id, 0);
        chk("single_data", log_data, 16'hABCD);

        // Requester 3 alone moves the pointer back to 0.
        cyc();
        req_valid = 4'b1000; req_data = {$urandom, $urandom};
        cyc();
        req_valid = 4'b1111;

        // Fairness: 0,1,2,3,0 with consecutive timestamps.
        for (int i = 0; i < 5; i++) begin
            cyc();
            req_data = {$urandom, $urandom};
            if (i == 4) log_ready = 1'b0;
            @(negedge clk);
            chk("rr_id", log_id, i % 4);
            chk("rr_valid", log_valid, 1);
            if (i > 0) chk("rr_ts_step", log_ts, prev_ts + 1);
            prev_ts = log_ts;
        end

        // Backpressure: record stays put for 4 cycles.
        for (int h = 0; h < 4; h++) begin
            if (h > 0) begin cyc(); @(negedge clk); end
            chk("hold_rdy", req_ready, 0);
            chk("hold_id", log_id, 0);
            chk("hold_ts", log_ts, prev_ts);
            chk("hold_valid", log_valid, 1);
        end
        cyc();
        log_ready = 1'b1;
        @(negedge clk);
        chk("release_rdy", req_ready, 4'b0010);
        cyc();
        @(negedge clk);
        chk("release_id", log_id, 1);
        chk("release_valid", log_valid, 1);

        // Discard mode: held record drains, requester 2 granted and dropped.
        cyc();
        log_en = 1'b0; req_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            chk("drop_rdy", req_ready, 4'b0100);
            chk("drop_valid", log_valid, i == 0);
        end
        cyc();
        req_valid = 4'b0;
        @(negedge clk);
        chk("drop_cnt3", drop_cnt, 3);
        chk("drop_valid_after", log_valid, 0);

        // Drop counter saturation.
        cyc();
        req_valid = 4'b1111;
        repeat (65540) cyc();
        @(negedge clk);
        chk("drop_sat", drop_cnt, 16'hFFFF);

        // 8-bit timestamp wrap.
        cyc();
        log_en = 1'b1; log_ready = 1'b1;
        n = 0;
        while (tsc8 != 8'hFF && n < 300) begin cyc(); n++; end
        chk("reach_tsc8_ff", tsc8, 8'hFF);
        cyc();
        @(negedge clk);
        chk("wrap_ts_ff", log_ts8, 8'hFF);
        cyc();
        @(negedge clk);
        chk("wrap_ts_00", log_ts8, 8'h00);

        // Random traffic including occasional mid-stream reset.
        for (int r = 0; r < 3000; r++) begin
            cyc();
            req_valid = 4'($urandom);
            req_data  = {$urandom, $urandom};
            log_en    = ($urandom_range(0, 7) != 0);
            log_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 199) == 0);
        end
        cyc();
        reset = 1'b0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
